// File: rtl/ray_tri_dispatch.sv
// rtl/ray_tri_dispatch.sv - issues one ray against N triangles and reduces in-order results to the closest hit
module ray_tri_dispatch #(
  parameter int IDX_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [0:1][0:2][31:0]    i_ray,
  input  logic [IDX_W-1:0]         i_num_tris,
  output logic                     o_busy,
  output logic                     o_tri_rd,
  output logic [IDX_W-1:0]         o_tri_addr,
  input  logic [0:2][0:2][31:0]    i_tri_data,
  output logic                     o_en,
  output logic [0:2][0:2][31:0]    o_tri,
  output logic [0:1][0:2][31:0]    o_ray,
  input  logic signed [31:0]       i_t,
  input  logic                     i_result,
  input  logic                     i_valid,
  output logic                     o_done,
  output logic                     o_hit,
  output logic signed [31:0]       o_t,
  output logic [IDX_W-1:0]         o_tri_idx,
  output logic                     o_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                  state, state_nx;
  logic [IDX_W-1:0]        num, issue, res_cnt, best_idx;
  logic [IDX_W:0]          outst;
  logic [WD_W-1:0]         wdog;
  logic signed [31:0]      best_t;
  logic                    hit, err, en;
  logic [0:1][0:2][31:0]   ray;

  logic active, start_ok, accept, wd_count, wd_fire, last_issue, last_result, better;

  assign active      = (state == FETCH) || (state == DRAIN);
  assign start_ok    = (state == IDLE) && i_start;
  assign accept      = active && i_valid;
  assign wd_count    = active && (outst != '0) && !i_valid;
  // Fires on the cycle whose idle count brings the watchdog up to TIMEOUT.
  assign wd_fire     = wd_count && (wdog >= WD_W'(TIMEOUT - 1));
  assign last_issue  = (state == FETCH) && (issue == num - IDX_W'(1));
  assign last_result = (outst == (IDX_W + 1)'(1)) && i_valid;
  assign better      = i_result && (!hit || (i_t < best_t));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_start) state_nx = (i_num_tris == '0) ? DONE : FETCH;
      FETCH:   if (last_issue) state_nx = DRAIN;
      DRAIN:   if (last_result || wd_fire) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      num      <= '0;
      issue    <= '0;
      res_cnt  <= '0;
      outst    <= '0;
      wdog     <= '0;
      best_t   <= 32'sh7fffffff;
      best_idx <= '0;
      hit      <= 1'b0;
      err      <= 1'b0;
      en       <= 1'b0;
      ray      <= '0;
    end else begin
      state <= state_nx;
      en    <= o_tri_rd;
      if (start_ok) begin
        issue    <= '0;
        res_cnt  <= '0;
        outst    <= '0;
        wdog     <= '0;
        best_t   <= 32'sh7fffffff;
        best_idx <= '0;
        hit      <= 1'b0;
        err      <= 1'b0;
        if (i_num_tris != '0) begin
          ray <= i_ray;
          num <= i_num_tris;
        end
      end else if (active) begin
        if (state == FETCH) issue <= issue + IDX_W'(1);
        outst <= outst + {{IDX_W{1'b0}}, o_tri_rd} - {{IDX_W{1'b0}}, accept};
        if (accept) begin
          res_cnt <= res_cnt + IDX_W'(1);
          if (better) begin
            hit      <= 1'b1;
            best_t   <= i_t;
            best_idx <= res_cnt;
          end
        end
        if (accept) wdog <= '0;
        else if (wd_count && wdog != WD_W'(TIMEOUT)) wdog <= wdog + WD_W'(1);
        if (state == DRAIN && wd_fire && !last_result) err <= 1'b1;
      end
    end
  end

  assign o_busy     = (state != IDLE);
  assign o_tri_rd   = (state == FETCH);
  assign o_tri_addr = issue;
  assign o_en       = en;
  assign o_tri      = i_tri_data;
  assign o_ray      = ray;
  assign o_done     = (state == DONE);
  assign o_hit      = hit;
  assign o_t        = best_t;
  assign o_tri_idx  = best_idx;
  assign o_err      = err;

endmodule
